// File: rtl/cdp_lut_idx_gen.sv
// -----------------------------------------------------------------------------
// cdp_lut_idx_gen
// Front end of the CDP LUT-interpolation path. Each signed 32-bit operand is
// turned into a LUT index plus a Q16 fraction, clamped on underflow/overflow.
// The two neighbouring LUT entries are fetched with one pair read, and an
// interpolation request (y0, y1, saturated base, scale, shift) is issued.
//
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   lut_in_pd/_vld/_rdy             : operand stream (signed x)
//   cfg_lut_start                   : signed table origin
//   cfg_lut_index_shift             : log2 of entry spacing (clamped to 16)
//   lut_rd_en / lut_rd_addr         : pair read of entries addr and addr+1
//   lut_rd_data_lo / _hi            : entries, valid one cycle after lut_rd_en
//   interp_in0_pd / interp_in1_pd   : y0 (sign-extended) / y1
//   interp_in_pd                    : int16-saturated y0, sign-extended
//   interp_in_scale / _shift        : {1'b0, frac} / constant 16
//   interp_in_vld / interp_in_rdy   : request handshake
//   cnt_clr, cnt_hit/uflow/oflow    : statistics counters
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready and, once raised, the payload is held
// until the transfer completes.
//
// Optional feature: define CDP_LUT_IDX_STAT_EN to build the saturating
// statistics counters. Without it the counters read 0 and cnt_clr is ignored.
// -----------------------------------------------------------------------------
module cdp_lut_idx_gen #(
   parameter int LUT_DEPTH = 65,
   parameter int LUT_AW    = 7
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic [31:0]       lut_in_pd,
   input  logic              lut_in_vld,
   output logic              lut_in_rdy,
   input  logic [31:0]       cfg_lut_start,
   input  logic [4:0]        cfg_lut_index_shift,
   output logic              lut_rd_en,
   output logic [LUT_AW-1:0] lut_rd_addr,
   input  logic [37:0]       lut_rd_data_lo,
   input  logic [37:0]       lut_rd_data_hi,
   output logic [38:0]       interp_in0_pd,
   output logic [37:0]       interp_in1_pd,
   output logic [16:0]       interp_in_pd,
   output logic [16:0]       interp_in_scale,
   output logic [5:0]        interp_in_shift,
   output logic              interp_in_vld,
   input  logic              interp_in_rdy,
   input  logic              cnt_clr,
   output logic [31:0]       cnt_hit,
   output logic [31:0]       cnt_uflow,
   output logic [31:0]       cnt_oflow
);

   localparam logic [32:0]       OFLOW_IDX  = 33'(LUT_DEPTH - 1);
   localparam logic [LUT_AW-1:0] OFLOW_ADDR = LUT_AW'(LUT_DEPTH - 2);

   // Stage A: classified operand waiting for its read slot
   logic              a_vld_q, a_vld_d;
   logic [LUT_AW-1:0] a_addr_q, a_addr_d;
   logic [15:0]       a_frac_q, a_frac_d;
   logic              a_uf_q, a_uf_d;
   logic              a_of_q, a_of_d;

   // Metadata of the read issued last cycle (data arrives this cycle)
   logic              rd_vld_q;
   logic [15:0]       rd_frac_q;
   logic              rd_uf_q, rd_of_q;

   // Two-entry in-order output buffer
   logic [37:0]       buf_y0_q   [2];
   logic [37:0]       buf_y1_q   [2];
   logic [15:0]       buf_frac_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        occ_q, occ_d;

   logic              accept, go, pop, push;
   logic [2:0]        occ_after;
   logic signed [32:0] diff;
   logic [4:0]        sh;
   logic [32:0]       idx;
   logic [31:0]       low_bits;
   logic              in_uf, in_of;
   logic [37:0]       push_y0, push_y1;
   logic [37:0]       out_y0, out_y1;
   logic [15:0]       out_frac, out_sat;

   // Handshake and read-slot control. A read is only issued when the buffer
   // is guaranteed to have room for its return one cycle later, because the
   // return itself cannot be stalled.
   assign pop           = interp_in_vld & interp_in_rdy;
   assign push          = rd_vld_q;
   assign interp_in_vld = (occ_q != 2'd0);
   assign occ_after     = {1'b0, occ_q} + {2'b0, rd_vld_q} - {2'b0, pop};
   assign go            = (occ_after < 3'd2);
   assign lut_rd_en     = a_vld_q & go;
   assign lut_rd_addr   = a_addr_q;
   assign lut_in_rdy    = ~a_vld_q | go;
   assign accept        = lut_in_vld & lut_in_rdy;

   // Operand classification and stage A next state
   always_comb begin
      diff     = $signed({lut_in_pd[31], lut_in_pd}) - $signed({cfg_lut_start[31], cfg_lut_start});
      sh       = (cfg_lut_index_shift > 5'd16) ? 5'd16 : cfg_lut_index_shift;
      idx      = $unsigned(diff) >> sh;
      low_bits = diff[31:0] & ((32'd1 << sh) - 32'd1);
      in_uf    = diff[32];
      in_of    = ~diff[32] & (idx >= OFLOW_IDX);

      a_vld_d  = a_vld_q;
      a_addr_d = a_addr_q;
      a_frac_d = a_frac_q;
      a_uf_d   = a_uf_q;
      a_of_d   = a_of_q;
      if (accept) begin
         a_vld_d = 1'b1;
         a_uf_d  = in_uf;
         a_of_d  = in_of;
         if (in_uf) begin
            a_addr_d = '0;
            a_frac_d = '0;
         end else if (in_of) begin
            a_addr_d = OFLOW_ADDR;
            a_frac_d = '0;
         end else begin
            a_addr_d = idx[LUT_AW-1:0];
            // remainder left-aligned into Q16
            a_frac_d = 16'(low_bits << (5'd16 - sh));
         end
      end else if (lut_rd_en) begin
         a_vld_d = 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         a_vld_q   <= 1'b0;
         a_addr_q  <= '0;
         a_frac_q  <= '0;
         a_uf_q    <= 1'b0;
         a_of_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_frac_q <= '0;
         rd_uf_q   <= 1'b0;
         rd_of_q   <= 1'b0;
      end else begin
         a_vld_q   <= a_vld_d;
         a_addr_q  <= a_addr_d;
         a_frac_q  <= a_frac_d;
         a_uf_q    <= a_uf_d;
         a_of_q    <= a_of_d;
         rd_vld_q  <= lut_rd_en;
         if (lut_rd_en) begin
            rd_frac_q <= a_frac_q;
            rd_uf_q   <= a_uf_q;
            rd_of_q   <= a_of_q;
         end
      end
   end

   // Clamped operands use a single entry for both ends so the interpolation
   // collapses to a constant regardless of frac.
   assign push_y0 = rd_of_q ? lut_rd_data_hi : lut_rd_data_lo;
   assign push_y1 = rd_uf_q ? lut_rd_data_lo : lut_rd_data_hi;
   assign occ_d   = occ_q + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            buf_y0_q[i]   <= '0;
            buf_y1_q[i]   <= '0;
            buf_frac_q[i] <= '0;
         end
      end else begin
         if (push) begin
            buf_y0_q[wr_ptr_q]   <= push_y0;
            buf_y1_q[wr_ptr_q]   <= push_y1;
            buf_frac_q[wr_ptr_q] <= rd_frac_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_d;
      end
   end

   // Output formation; payload reads zero whenever no request is pending
   always_comb begin
      out_y0   = interp_in_vld ? buf_y0_q[rd_ptr_q]   : '0;
      out_y1   = interp_in_vld ? buf_y1_q[rd_ptr_q]   : '0;
      out_frac = interp_in_vld ? buf_frac_q[rd_ptr_q] : '0;
      if ($signed(out_y0) > 38'sd32767) begin
         out_sat = 16'h7fff;
      end else if ($signed(out_y0) < -38'sd32768) begin
         out_sat = 16'h8000;
      end else begin
         out_sat = out_y0[15:0];
      end
   end

   assign interp_in0_pd   = {out_y0[37], out_y0};
   assign interp_in1_pd   = out_y1;
   assign interp_in_pd    = {out_sat[15], out_sat};
   assign interp_in_scale = {1'b0, out_frac};
   assign interp_in_shift = 6'd16;

`ifdef CDP_LUT_IDX_STAT_EN
   logic [31:0] cnt_hit_q, cnt_uflow_q, cnt_oflow_q;

   // Counters saturate; clear wins over a same-cycle increment
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst || cnt_clr) begin
         cnt_hit_q   <= '0;
         cnt_uflow_q <= '0;
         cnt_oflow_q <= '0;
      end else if (accept) begin
         if (in_uf) begin
            if (cnt_uflow_q != 32'hffff_ffff) cnt_uflow_q <= cnt_uflow_q + 32'd1;
         end else if (in_of) begin
            if (cnt_oflow_q != 32'hffff_ffff) cnt_oflow_q <= cnt_oflow_q + 32'd1;
         end else begin
            if (cnt_hit_q != 32'hffff_ffff) cnt_hit_q <= cnt_hit_q + 32'd1;
         end
      end
   end

   assign cnt_hit   = cnt_hit_q;
   assign cnt_uflow = cnt_uflow_q;
   assign cnt_oflow = cnt_oflow_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign cnt_hit   = '0;
   assign cnt_uflow = '0;
   assign cnt_oflow = '0;
`endif

endmodule
